// File: rtl/bcd_pkg.sv
// Shared widths, iteration bound and FSM states for
// the double-dabble binary to BCD converter.
package bcd_pkg;

  localparam int BIN_W      = 12;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 16;
  localparam int CNT_W      = 4;

  localparam logic [CNT_W-1:0] ITER_LAST = 4'd11;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: adds 3 to a
// BCD nibble of 5 or more before it is doubled.
module bcd_add3 (
  input  logic [3:0] d,
  input  logic [3:0] q_unused_guard,
  output logic [3:0] q
);

  logic unused;

  assign unused = ^q_unused_guard;
  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Free-running 12-bit binary to 4-digit packed BCD
// converter, one double-dabble iteration per cycle.
module binary_to_bcd_converter
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] binary_in,
  output logic [BCD_W-1:0] bcd_out
);

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0]       cnt_q;
  logic [BIN_W-1:0]       bin_q;
  logic [BCD_W-1:0]       scr_q;
  logic [BCD_W-1:0]       scr_adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .d              (scr_q[4*g +: 4]),
      .q_unused_guard (4'd0),
      .q              (scr_adj[4*g +: 4])
    );
  end

  // Scratch and binary shift as one 28-bit word
  assign shifted = {scr_adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == ITER_LAST) state_d = DONE;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_out <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          bin_q <= binary_in;
          scr_q <= '0;
          cnt_q <= '0;
        end
        SHIFT: begin
          {scr_q, bin_q} <= shifted;
          cnt_q          <= cnt_q + 4'd1;
        end
        DONE: begin
          bcd_out <= scr_q;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Bench for binary_to_bcd_converter: boundary table,
// reset and toggle sequences, random free-running stream.
module tb_binary_to_bcd_converter;

  logic        clk;
  logic        rst;
  logic [11:0] binary_in;
  logic [15:0] bcd_out;

  int checks;
  int fails;
  int ec;

  typedef struct {
    logic [11:0] bin;
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs[7];

  binary_to_bcd_converter dut (
    .clk       (clk),
    .rst       (rst),
    .binary_in (binary_in),
    .bcd_out   (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)",
               name, act, exp, ec);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      ec++;
      #1;
    end
  endtask

  // Async assert, check immediate clear, release on a negedge
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_async_clear", bcd_out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    ec  = 0;
  endtask

  // Model: value sampled on LOAD edges, published on DONE edges
  task automatic run_stream(input string name,
                            input int ncyc,
                            input bit rnd_full);
    logic [11:0] lat;
    logic [15:0] exp_out;
    lat     = '0;
    exp_out = 16'h0000;
    for (int i = 0; i < ncyc; i++) begin
      tick(1);
      if (ec % 14 == 1) lat = binary_in;
      if (ec % 14 == 0) exp_out = to_bcd(int'(lat));
      chk(name, bcd_out, exp_out);
      if ($urandom_range(0, 2) == 0) begin
        if (rnd_full)
          binary_in = 12'($urandom_range(0, 4095));
        else
          binary_in = ($urandom_range(0, 1) == 1) ? 12'd658 : 12'd247;
      end
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    ec        = 0;
    rst       = 1'b0;
    binary_in = 12'h000;

    vecs[0] = '{12'h000, 16'h0000};
    vecs[1] = '{12'hFFF, 16'h4095};
    vecs[2] = '{12'd999, 16'h0999};
    vecs[3] = '{12'd1000, 16'h1000};
    vecs[4] = '{12'h4B4, 16'h1204};
    vecs[5] = '{12'h0F7, 16'h0247};
    vecs[6] = '{12'h292, 16'h0658};

    #12;
    chk("reset_state", bcd_out, 16'h0000);

    for (int i = 0; i < 7; i++) begin
      binary_in = vecs[i].bin;
      do_reset();
      tick(13);
      chk("vec_before_done", bcd_out, 16'h0000);
      tick(1);
      chk("vec_first_done", bcd_out, vecs[i].bcd);
      tick(16);
      chk("vec_stable", bcd_out, vecs[i].bcd);
    end

    // Reset pulse in the middle of the second conversion
    binary_in = 12'd658;
    do_reset();
    tick(14);
    chk("pre_mid_reset", bcd_out, 16'h0658);
    tick(5);
    rst = 1'b0;
    #1;
    chk("mid_reset_async", bcd_out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    ec  = 0;
    tick(13);
    chk("post_reset_edge13", bcd_out, 16'h0000);
    tick(1);
    chk("post_reset_edge14", bcd_out, 16'h0658);

    binary_in = 12'd247;
    do_reset();
    run_stream("toggle_247_658", 84, 1'b0);

    binary_in = 12'($urandom_range(0, 4095));
    do_reset();
    run_stream("random_stream", 420, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_converter.md
# binary_to_bcd_converter

Sequential 12-bit binary to 4-digit packed BCD converter using the shift-and-add-3 (double-dabble) algorithm. It runs continuously: it samples `binary_in`, converts it over a fixed number of clock cycles, publishes the result on a registered `bcd_out`, then starts again. It sits between a binary counter or arithmetic datapath and the 7-segment display driver, which consumes one BCD nibble per digit.

## Interface
- No parameters. Widths are fixed: 12-bit input, 16-bit output.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `binary_in`  input  12  unsigned binary value, 0..4095; sampled only in LOAD.
- `bcd_out`  output  16  packed BCD, registered:
  - [15:12] thousands
  - [11:8] hundreds
  - [7:4] tens
  - [3:0] ones

## Operation
- Internal registers:
  - 12-bit binary shift register.
  - 16-bit BCD scratch register.
  - 4-bit iteration counter.
  - State register.
  - `bcd_out` register.
- FSM states LOAD, SHIFT, DONE:
  - LOAD: binary shift reg <= `binary_in`; scratch <= 0; counter <= 0; next SHIFT.
  - SHIFT, one iteration per cycle:
    - Adjust each scratch nibble: if >= 5, add 3.
    - Shift {adjusted scratch, binary shift reg} left by 1 as one 28-bit quantity.
    - counter <= counter + 1.
    - After the 12th iteration (counter was 11), next DONE.
  - DONE: `bcd_out` <= scratch; next LOAD.
- Nibble adjust is combinational and applied to all four nibbles in parallel within the same cycle as the shift.
- The thousands nibble never exceeds 4, since the maximum input 4095 gives 0x4095. No overflow handling is needed.
- `bcd_out` changes only in DONE and holds its value otherwise.
- Changes on `binary_in` outside LOAD have no effect on the conversion in progress.
- Reset (`rst` = 0, at any time, including mid-conversion):
  - State -> LOAD.
  - Counter, shift registers and scratch cleared.
  - `bcd_out` = 16'h0000 immediately, without waiting for a clock edge.

## Timing
- Conversion period: exactly 14 cycles (1 LOAD + 12 SHIFT + 1 DONE), repeating indefinitely.
- If LOAD occurs at edge k:
  - SHIFT iterations occur at edges k+1..k+12.
  - `bcd_out` is valid after edge k+13.
  - The next LOAD occurs at edge k+14.
- After reset release, the first LOAD is at the first rising edge, and the first valid `bcd_out` appears 14 edges after release.
- Worst-case delay from a `binary_in` change to the matching `bcd_out` is 28 cycles.
- A stable input yields a stable `bcd_out`: each DONE rewrites the same value, so there are no glitches.
- Reset deassertion is sampled on `clk`; the reset-to-LOAD path is asynchronous.

## Structure
- Shared package `bcd_pkg` holds:
  - `BIN_W` = 12, `BCD_DIGITS` = 4, `BCD_W` = 16.
  - `ITER_LAST` = 11.
  - State enum {LOAD, SHIFT, DONE}.
- Sub-module `bcd_add3`: 4-bit in, 4-bit out, adds 3 when the input is >= 5. Four instances are used, one per digit.
- Top-level module holds the FSM, counter, shift registers and output register.

## Test plan
- `binary_in` = 12'h4B4 (1204), held for 30 cycles -> `bcd_out` = 16'h1204 within 28 cycles, stable afterwards.
- `binary_in` = 12'h0F7 (247) -> `bcd_out` = 16'h0247; `binary_in` = 12'h292 (658) -> `bcd_out` = 16'h0658.
- Boundaries:
  - 12'h000 -> 16'h0000.
  - 12'hFFF (4095) -> 16'h4095.
  - 12'd999 -> 16'h0999.
  - 12'd1000 -> 16'h1000.
- Pulse `rst` low mid-SHIFT with 658 applied -> `bcd_out` goes to 16'h0000 without a clock edge; 16'h0658 appears exactly 14 edges after release.
- Toggle `binary_in` between 247 and 658 during SHIFT cycles -> `bcd_out` only ever shows 16'h0247 or 16'h0658 and updates only on DONE edges, every 14 cycles.
